// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: byte width and the
// launch FSM state encoding used by uart_tx_feeder.
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_DONE = 2'd1,
    ST_GUARD     = 2'd2
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with registered full/empty/count flags.
// The head entry is presented combinationally on rd_data.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam logic [AW-1:0] PTR_INC = AW'(1);
  localparam logic [CW-1:0] CNT_INC = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_full;
  logic             r_empty;

  logic             w_wr_ok;
  logic             w_rd_ok;
  logic [CW-1:0]    w_count_nxt;

  // Acceptance uses only the registered flags, never the same-cycle opposite operation.
  assign w_wr_ok = wr_en & ~r_full;
  assign w_rd_ok = rd_en & ~r_empty;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_ok, w_rd_ok})
      2'b10:   w_count_nxt = r_count + CNT_INC;
      2'b01:   w_count_nxt = r_count - CNT_INC;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + PTR_INC;
      if (w_rd_ok) r_rd_ptr <= r_rd_ptr + PTR_INC;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_MAX);
      r_empty <= (w_count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[r_wr_ptr] <= wr_data;
  end

  assign rd_data = r_mem[r_rd_ptr];
  assign full    = r_full;
  assign empty   = r_empty;
  assign count   = r_count;

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus launch FSM feeding uart_tx one byte per frame through the
// Tx_Start / Tx_Active / Tx_Done handshake.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Wr_En,
  input  logic [BYTE_W-1:0] Wr_Data,
  output logic              Full,
  output logic              Empty,
  output logic [CNT_W-1:0]  Count,
  output logic              Overflow,
  output logic              Tx_Start,
  output logic [BYTE_W-1:0] Tx_Byte,
  input  logic              Tx_Active,
  input  logic              Tx_Done
);

  tx_state_e         r_state;
  tx_state_e         w_state_nxt;
  logic              w_pop;
  logic [BYTE_W-1:0] w_head;
  logic              w_full;
  logic              w_empty;
  logic [CNT_W-1:0]  w_count;

  logic              r_tx_start;
  logic [BYTE_W-1:0] r_tx_byte;
  logic              r_overflow;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (BYTE_W)
  ) u_fifo (
    .clk     (Clk),
    .rst     (Rst),
    .wr_en   (Wr_En),
    .wr_data (Wr_Data),
    .rd_en   (w_pop),
    .rd_data (w_head),
    .full    (w_full),
    .empty   (w_empty),
    .count   (w_count)
  );

  // Reset lands in GUARD: uart_tx may still be mid-frame and is not reset here.
  always_ff @(posedge Clk) begin
    if (Rst) r_state <= ST_GUARD;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_WAIT_DONE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
        if (Tx_Done) w_state_nxt = ST_GUARD;
        else         w_state_nxt = ST_WAIT_DONE;
      end
      ST_GUARD: begin
        if (!Tx_Active && !Tx_Done) w_state_nxt = ST_IDLE;
        else                        w_state_nxt = ST_GUARD;
      end
      default: w_state_nxt = ST_GUARD;
    endcase
  end

  // Launch pulse and byte are registered from the pop decision.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_tx_start <= 1'b0;
      r_tx_byte  <= 8'h00;
      r_overflow <= 1'b0;
    end else begin
      r_tx_start <= w_pop;
      if (w_pop) r_tx_byte <= w_head;
      r_overflow <= Wr_En & w_full;
    end
  end

  assign Full     = w_full;
  assign Empty    = w_empty;
  assign Count    = w_count;
  assign Overflow = r_overflow;
  assign Tx_Start = r_tx_start;
  assign Tx_Byte  = r_tx_byte;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder with a behavioural uart_tx stand-in
// that records every launched byte as a received frame.
module tb_uart_tx_feeder;

  localparam int FRAME    = 40;
  localparam int DONE_LEN = 2;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       Wr_En = 1'b0;
  logic [7:0] Wr_Data = 8'h00;
  logic       Full, Empty, Overflow, Tx_Start;
  logic [4:0] Count;
  logic [7:0] Tx_Byte;
  logic       tx_active_s, tx_done_s;

  logic       manual = 1'b0;
  logic       man_active = 1'b0;
  logic       man_done = 1'b0;
  logic       m_active = 1'b0;
  logic       m_done = 1'b0;
  int         m_phase = 0;
  int         m_cnt = 0;
  logic [7:0] m_shift = 8'h00;
  logic       prev_start = 1'b0;
  int         viol = 0;
  logic [7:0] rx_log [256];
  int         rx_n = 0;

  int checks = 0;
  int errors = 0;

  assign tx_active_s = manual ? man_active : m_active;
  assign tx_done_s   = manual ? man_done   : m_done;

  uart_tx_feeder #(.DEPTH(16)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Wr_En     (Wr_En),
    .Wr_Data   (Wr_Data),
    .Full      (Full),
    .Empty     (Empty),
    .Count     (Count),
    .Overflow  (Overflow),
    .Tx_Start  (Tx_Start),
    .Tx_Byte   (Tx_Byte),
    .Tx_Active (tx_active_s),
    .Tx_Done   (tx_done_s)
  );

  always #5 Clk = ~Clk;

  // uart_tx stand-in plus launch-rule monitor
  always @(posedge Clk) begin
    prev_start <= Tx_Start;
    if (Tx_Start && (tx_active_s || tx_done_s || prev_start)) viol <= viol + 1;
    if (!manual) begin
      case (m_phase)
        0: if (Tx_Start) begin
             m_shift  <= Tx_Byte;
             m_active <= 1'b1;
             m_cnt    <= FRAME - 1;
             m_phase  <= 1;
           end
        1: if (m_cnt == 0) begin
             m_active <= 1'b0;
             m_done   <= 1'b1;
             m_cnt    <= DONE_LEN - 1;
             m_phase  <= 2;
             rx_log[rx_n[7:0]] <= m_shift;
             rx_n     <= rx_n + 1;
           end else m_cnt <= m_cnt - 1;
        default: if (m_cnt == 0) begin
             m_done  <= 1'b0;
             m_phase <= 0;
           end else m_cnt <= m_cnt - 1;
      endcase
    end
  end

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       a;
    logic       dn;
    logic       full;
    logic       empty;
    logic [4:0] cnt;
    logic       ovf;
    logic       start;
    logic [7:0] byt;
  } vec_t;

  vec_t vecs[$];

  function automatic void addv(logic wr, logic [7:0] d, logic a, logic dn, logic f,
                               logic e, logic [4:0] c, logic o, logic s, logic [7:0] b);
    vecs.push_back('{wr, d, a, dn, f, e, c, o, s, b});
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic wait_rx(input int target, input string nm);
    int n = 0;
    while (rx_n < target && n < 3000) begin
      @(negedge Clk);
      n++;
    end
    chk(nm, 32'(rx_n >= target), 32'd1);
  endtask

  task automatic wait_quiet();
    int n = 0;
    while (m_phase != 0 && n < 200) begin
      @(negedge Clk);
      n++;
    end
    repeat (4) @(negedge Clk);
  endtask

  task automatic burst(input logic [7:0] first, input int n, output int maxc, output int ovfs);
    maxc = 0;
    ovfs = 0;
    for (int i = 0; i < n; i++) begin
      Wr_En   = 1'b1;
      Wr_Data = first + 8'(i);
      @(negedge Clk);
      if (int'(Count) > maxc) maxc = int'(Count);
      if (Overflow) ovfs++;
    end
    Wr_En = 1'b0;
  endtask

  initial begin
    int base, maxc, ovfs;
    logic seen;

    // reset state
    repeat (2) @(negedge Clk);
    chk("rst_full", 32'(Full), 32'd0);
    chk("rst_empty", 32'(Empty), 32'd1);
    chk("rst_count", 32'(Count), 32'd0);
    chk("rst_ovf", 32'(Overflow), 32'd0);
    chk("rst_start", 32'(Tx_Start), 32'd0);
    chk("rst_byte", 32'(Tx_Byte), 32'h00);
    Rst = 1'b0;

    seen = 1'b0;
    repeat (50) begin
      @(negedge Clk);
      seen = seen | Tx_Start;
    end
    chk("idle_no_start", 32'(seen), 32'd0);
    chk("idle_empty", 32'(Empty), 32'd1);
    chk("idle_count", 32'(Count), 32'd0);

    // table: handshake driven directly, FSM starts in GUARD after reset
    addv(1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 8'h00);
    addv(1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0, 8'h00);
    addv(1'b0, 8'h99, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0, 8'h00);
    addv(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b1, 8'h11);
    addv(1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0, 8'h11);
    addv(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0, 8'h11);
    addv(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0, 8'h11);
    addv(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0, 8'h11);
    addv(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b1, 8'h22);
    for (int i = 0; i < 15; i++)
      addv(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0, (i == 14), 1'b0, 5'(i + 2), 1'b0, 1'b0, 8'h22);
    addv(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1, 1'b0, 5'd16, 1'b1, 1'b0, 8'h22);
    addv(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 5'd16, 1'b0, 1'b0, 8'h22);
    addv(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 5'd16, 1'b0, 1'b0, 8'h22);
    addv(1'b1, 8'hEF, 1'b0, 1'b0, 1'b0, 1'b0, 5'd15, 1'b1, 1'b1, 8'h33);
    addv(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd15, 1'b0, 1'b0, 8'h33);
    addv(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 5'd15, 1'b0, 1'b0, 8'h33);
    addv(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd15, 1'b0, 1'b0, 8'h33);

    manual = 1'b1;
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      Wr_En      = vecs[i].wr;
      Wr_Data    = vecs[i].d;
      man_active = vecs[i].a;
      man_done   = vecs[i].dn;
      @(negedge Clk);
      if (Full !== vecs[i].full || Empty !== vecs[i].empty || Count !== vecs[i].cnt ||
          Overflow !== vecs[i].ovf || Tx_Start !== vecs[i].start || Tx_Byte !== vecs[i].byt) begin
        $display("FAIL vec%0d actual f=%b e=%b c=%0d o=%b s=%b b=%h required f=%b e=%b c=%0d o=%b s=%b b=%h",
                 i, Full, Empty, Count, Overflow, Tx_Start, Tx_Byte, vecs[i].full, vecs[i].empty,
                 vecs[i].cnt, vecs[i].ovf, vecs[i].start, vecs[i].byt);
        errors++;
      end
      checks++;
    end
    Wr_En = 1'b0;
    man_done = 1'b0;
    man_active = 1'b0;
    manual = 1'b0;

    // remaining 15 bytes drain in order through the stand-in
    base = rx_n;
    wait_rx(base + 15, "table_drain_timeout");
    for (int i = 0; i < 15; i++)
      chk($sformatf("table_rx%0d", i), 32'(rx_log[(base + i) % 256]), 32'(8'h40 + 8'(i)));
    wait_quiet();

    // single write: launch two edges after the write
    base = rx_n;
    Wr_En = 1'b1;
    Wr_Data = 8'hA5;
    @(negedge Clk);
    Wr_En = 1'b0;
    chk("single_start_early", 32'(Tx_Start), 32'd0);
    chk("single_empty", 32'(Empty), 32'd0);
    @(negedge Clk);
    chk("single_start", 32'(Tx_Start), 32'd1);
    chk("single_byte", 32'(Tx_Byte), 32'hA5);
    wait_rx(base + 1, "single_rx_timeout");
    chk("single_rx", 32'(rx_log[base % 256]), 32'hA5);
    wait_quiet();

    // 16-byte burst fits
    base = rx_n;
    burst(8'h01, 16, maxc, ovfs);
    chk("b16_peak", 32'(maxc == 15 || maxc == 16), 32'd1);
    chk("b16_ovf", 32'(ovfs), 32'd0);
    wait_rx(base + 16, "b16_rx_timeout");
    for (int i = 0; i < 16; i++)
      chk($sformatf("b16_rx%0d", i), 32'(rx_log[(base + i) % 256]), 32'(8'h01 + 8'(i)));
    wait_quiet();

    // 20-byte burst: first pops, 16 more fill, last 3 rejected
    base = rx_n;
    burst(8'h80, 20, maxc, ovfs);
    chk("b20_peak", 32'(maxc), 32'd16);
    chk("b20_ovf", 32'(ovfs), 32'd3);
    wait_rx(base + 17, "b20_rx_timeout");
    for (int i = 0; i < 17; i++)
      chk($sformatf("b20_rx%0d", i), 32'(rx_log[(base + i) % 256]), 32'(8'h80 + 8'(i)));
    repeat (200) @(negedge Clk);
    chk("b20_no_extra", 32'(rx_n), 32'(base + 17));
    wait_quiet();

    // reset mid-frame with 5 bytes queued
    base = rx_n;
    burst(8'hC0, 6, maxc, ovfs);
    chk("mid_count", 32'(Count), 32'd5);
    repeat (10) @(negedge Clk);
    chk("mid_busy", 32'(m_active), 32'd1);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    chk("mid_rst_count", 32'(Count), 32'd0);
    chk("mid_rst_empty", 32'(Empty), 32'd1);
    chk("mid_rst_byte", 32'(Tx_Byte), 32'h00);
    wait_rx(base + 1, "mid_frame_timeout");
    chk("mid_frame_rx", 32'(rx_log[base % 256]), 32'hC0);
    repeat (60) @(negedge Clk);
    chk("mid_no_retx", 32'(rx_n), 32'(base + 1));
    Wr_En = 1'b1;
    Wr_Data = 8'h3C;
    @(negedge Clk);
    Wr_En = 1'b0;
    wait_rx(base + 2, "mid_3c_timeout");
    chk("mid_3c_rx", 32'(rx_log[(base + 1) % 256]), 32'h3C);
    wait_quiet();

    chk("launch_rules", 32'(viol), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
